// File: rtl/pulse_period_monitor_if.sv
// Signal bundle between a pulse source/observer and pulse_period_monitor.
// The err_count signal exists only when PULSE_MON_ERRCNT_EN is defined.
interface pulse_period_monitor_if #(
   parameter int N = 3
) ();
   localparam int W = $clog2(2*N+1);

   logic         enable;
   logic         pulse_in;
   logic         locked;
   logic         period_err;
   logic         timeout;
   logic [W-1:0] meas_period;
`ifdef PULSE_MON_ERRCNT_EN
   logic [7:0]   err_count;

   modport slave  (input  enable, pulse_in,
                   output locked, period_err, timeout, meas_period, err_count);
   modport master (output enable, pulse_in,
                   input  locked, period_err, timeout, meas_period, err_count);
`else
   modport slave  (input  enable, pulse_in,
                   output locked, period_err, timeout, meas_period);
   modport master (output enable, pulse_in,
                   input  locked, period_err, timeout, meas_period);
`endif
endinterface

// File: rtl/pulse_period_monitor.sv
// Checks that single-cycle pulses arrive every N clk cycles and locks after LOCK_CNT good intervals.
// Define PULSE_MON_ERRCNT_EN to add the saturating err_count output.
module pulse_period_monitor #(
   parameter int N        = 3,
   parameter int LOCK_CNT = 4
) (
   input  logic                  clk,
   input  logic                  resetn,
   pulse_period_monitor_if.slave mon
);
   localparam int             W        = $clog2(2*N+1);
   localparam logic [W-1:0]   ICNT_MAX = W'(2*N-1);
   localparam logic [W-1:0]   N_W      = W'(N);
   localparam logic [7:0]     LOCK_W   = 8'(LOCK_CNT);

   typedef enum logic [1:0] {IDLE, SEEK, ACQ, LOCKED} state_t;

   state_t       state;
   logic [W-1:0] icnt;
   logic [7:0]   good;
   logic [7:0]   good_next;
   logic         locked_q;
   logic         period_err_q;
   logic         timeout_q;
   logic [W-1:0] meas_q;
   logic [W-1:0] interval;
   logic         tracking;
   logic         bad_ev;
   logic         timeout_ev;

   // interval can reach 2N, which still fits in W bits
   assign interval   = icnt + W'(1);
   assign good_next  = good + 8'd1;
   assign tracking   = (state == ACQ) || (state == LOCKED);
   assign bad_ev     = mon.enable && tracking && mon.pulse_in && (interval != N_W);
   // a pulse in the last cycle wins over timeout and is evaluated as interval 2N
   assign timeout_ev = mon.enable && tracking && !mon.pulse_in && (icnt == ICNT_MAX);

   // NOTE: all state is updated with non-blocking assignments so every register
   // in this block samples the same pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state        <= IDLE;
         icnt         <= '0;
         good         <= '0;
         locked_q     <= 1'b0;
         period_err_q <= 1'b0;
         timeout_q    <= 1'b0;
         meas_q       <= '0;
      end else begin
         period_err_q <= bad_ev;
         timeout_q    <= timeout_ev;
         if (!mon.enable) begin
            state    <= IDLE;
            icnt     <= '0;
            good     <= '0;
            locked_q <= 1'b0;
         end else begin
            case (state)
               IDLE: state <= SEEK;
               SEEK: begin
                  if (mon.pulse_in) begin
                     state <= ACQ;
                     icnt  <= '0;
                     good  <= '0;
                  end
               end
               ACQ, LOCKED: begin
                  if (mon.pulse_in) begin
                     icnt   <= '0;
                     meas_q <= interval;
                     if (bad_ev) begin
                        state    <= ACQ;
                        good     <= '0;
                        locked_q <= 1'b0;
                     end else if (state == ACQ) begin
                        good <= good_next;
                        if (good_next == LOCK_W) begin
                           state    <= LOCKED;
                           locked_q <= 1'b1;
                        end
                     end
                  end else if (timeout_ev) begin
                     state    <= SEEK;
                     icnt     <= '0;
                     good     <= '0;
                     locked_q <= 1'b0;
                  end else begin
                     icnt <= icnt + W'(1);
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   assign mon.locked      = locked_q;
   assign mon.period_err  = period_err_q;
   assign mon.timeout     = timeout_q;
   assign mon.meas_period = meas_q;

`ifdef PULSE_MON_ERRCNT_EN
   logic [7:0] err_count_q;

   // survives enable=0; only reset clears the history
   always_ff @(posedge clk) begin
      if (!resetn) begin
         err_count_q <= '0;
      end else if ((bad_ev || timeout_ev) && (err_count_q != 8'hFF)) begin
         err_count_q <= err_count_q + 8'd1;
      end
   end

   assign mon.err_count = err_count_q;
`endif

endmodule

// File: tb/tb_pulse_period_monitor.sv
// Self-checking bench for pulse_period_monitor: directed scenarios plus randomized traffic
// against a timestamp-based reference model. Honours PULSE_MON_ERRCNT_EN.
module tb_pulse_period_monitor;
   localparam int N        = 3;
   localparam int LOCK_CNT = 4;
   localparam int W        = $clog2(2*N+1);

   logic clk    = 1'b0;
   logic resetn = 1'b0;
   always #5 clk = ~clk;

   pulse_period_monitor_if #(.N(N)) mon ();
   pulse_period_monitor #(.N(N), .LOCK_CNT(LOCK_CNT)) dut (
      .clk    (clk),
      .resetn (resetn),
      .mon    (mon)
   );

   int checks = 0;
   int errors = 0;

   // reference model: works from pulse timestamps rather than a running counter
   int cyc      = 0;
   bit m_active = 0;
   bit m_track  = 0;
   int m_last   = 0;
   int m_good   = 0;
   bit m_locked = 0;
   bit m_perr   = 0;
   bit m_tout   = 0;
   int m_meas   = 0;
   int m_errc   = 0;

   task automatic model_step(input bit rst_n, input bit en, input bit p);
      int gap;
      cyc++;
      m_perr = 0;
      m_tout = 0;
      if (!rst_n) begin
         m_active = 0; m_track = 0; m_good = 0; m_locked = 0; m_meas = 0; m_errc = 0;
      end else if (!en) begin
         m_active = 0; m_track = 0; m_good = 0; m_locked = 0;
      end else if (!m_active) begin
         m_active = 1;
      end else if (!m_track) begin
         if (p) begin
            m_track = 1; m_last = cyc; m_good = 0;
         end
      end else begin
         gap = cyc - m_last;
         if (p) begin
            m_meas = gap;
            m_last = cyc;
            if (gap != N) begin
               m_perr = 1; m_good = 0; m_locked = 0;
            end else if (!m_locked) begin
               m_good++;
               if (m_good >= LOCK_CNT) m_locked = 1;
            end
         end else if (gap >= 2*N) begin
            m_tout = 1; m_track = 0; m_good = 0; m_locked = 0;
         end
      end
      if (rst_n && (m_perr || m_tout) && m_errc < 255) m_errc++;
   endtask

   function automatic logic [W+2:0] model_vec();
      return {m_locked, m_perr, m_tout, W'(m_meas)};
   endfunction

   logic [W+2:0] obs;
   assign obs = {mon.locked, mon.period_err, mon.timeout, mon.meas_period};

   // inputs change 1 time unit after the edge; outputs are sampled there too
   task automatic tick(input bit en, input bit p);
      mon.enable   = en;
      mon.pulse_in = p;
      @(posedge clk);
      model_step(resetn, en, p);
      #1;
   endtask

   task automatic pulse_after(input int g);
      for (int i = 1; i < g; i++) tick(1'b1, 1'b0);
      tick(1'b1, 1'b1);
   endtask

   task automatic start_locked();
      resetn = 1'b0;
      tick(1'b0, 1'b0);
      resetn = 1'b1;
      tick(1'b1, 1'b0);
      tick(1'b1, 1'b1);
      repeat (LOCK_CNT) pulse_after(N);
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      tick(1'b1, 1'b1);
      tick(1'b1, 1'b1);
      checks++;
      if (obs !== '0) begin
         errors++;
         $display("FAIL reset outputs got %b want %b", obs, {(W+3){1'b0}});
      end
`ifdef PULSE_MON_ERRCNT_EN
      checks++;
      if (mon.err_count !== 8'd0) begin
         errors++;
         $display("FAIL reset err_count got %0d want 0", mon.err_count);
      end
`endif
      resetn = 1'b1;
   endtask

   task automatic test_lock();
      logic want_l;
      tick(1'b1, 1'b0);
      tick(1'b1, 1'b1);
      checks++;
      if (obs !== {1'b0, 1'b0, 1'b0, W'(0)}) begin
         errors++;
         $display("FAIL first_pulse got %b want all zero", obs);
      end
      for (int k = 1; k <= LOCK_CNT; k++) begin
         pulse_after(N);
         want_l = (k == LOCK_CNT);
         checks++;
         if (obs !== {want_l, 1'b0, 1'b0, W'(N)}) begin
            errors++;
            $display("FAIL lock k=%0d got %b want %b", k, obs, {want_l, 1'b0, 1'b0, W'(N)});
         end
         checks++;
         if (obs !== model_vec()) begin
            errors++;
            $display("FAIL lock_model k=%0d got %b want %b", k, obs, model_vec());
         end
      end
   endtask

   task automatic test_bad_interval();
      logic want_l;
      start_locked();
      pulse_after(2);
      checks++;
      if (obs !== {1'b0, 1'b1, 1'b0, W'(2)}) begin
         errors++;
         $display("FAIL bad_interval got %b want %b", obs, {1'b0, 1'b1, 1'b0, W'(2)});
      end
      tick(1'b1, 1'b0);
      checks++;
      if (mon.period_err !== 1'b0) begin
         errors++;
         $display("FAIL perr_width got %b want 0", mon.period_err);
      end
      pulse_after(N - 1);
      for (int k = 2; k <= LOCK_CNT; k++) begin
         pulse_after(N);
         want_l = (k == LOCK_CNT);
         checks++;
         if (mon.locked !== want_l || mon.period_err !== 1'b0) begin
            errors++;
            $display("FAIL relock k=%0d got locked=%b perr=%b want locked=%b perr=0",
                     k, mon.locked, mon.period_err, want_l);
         end
      end
   endtask

   task automatic test_timeout();
      logic want_t;
      start_locked();
      for (int i = 1; i <= 2*N; i++) begin
         tick(1'b1, 1'b0);
         want_t = (i == 2*N);
         checks++;
         if (mon.timeout !== want_t || mon.locked !== !want_t) begin
            errors++;
            $display("FAIL timeout i=%0d got tout=%b locked=%b want tout=%b locked=%b",
                     i, mon.timeout, mon.locked, want_t, !want_t);
         end
      end
      tick(1'b1, 1'b0);
      checks++;
      if (mon.timeout !== 1'b0 || mon.locked !== 1'b0) begin
         errors++;
         $display("FAIL timeout_width got tout=%b locked=%b want 0 0", mon.timeout, mon.locked);
      end
      tick(1'b1, 1'b1);
      checks++;
      if (obs !== {1'b0, 1'b0, 1'b0, W'(N)}) begin
         errors++;
         $display("FAIL seek_pulse got %b want %b", obs, {1'b0, 1'b0, 1'b0, W'(N)});
      end
      pulse_after(2*N);
      checks++;
      if (obs !== {1'b0, 1'b1, 1'b0, W'(2*N)}) begin
         errors++;
         $display("FAIL pulse_at_2n got %b want %b", obs, {1'b0, 1'b1, 1'b0, W'(2*N)});
      end
      tick(1'b1, 1'b0);
      checks++;
      if (mon.timeout !== 1'b0 || mon.period_err !== 1'b0) begin
         errors++;
         $display("FAIL after_2n got tout=%b perr=%b want 0 0", mon.timeout, mon.period_err);
      end
   endtask

   task automatic test_reset_mid_lock();
      logic want_l;
      start_locked();
      checks++;
      if (mon.locked !== 1'b1) begin
         errors++;
         $display("FAIL pre_reset_lock got %b want 1", mon.locked);
      end
      resetn = 1'b0;
      tick(1'b1, 1'b1);
      resetn = 1'b1;
      checks++;
      if (obs !== '0) begin
         errors++;
         $display("FAIL mid_lock_reset got %b want all zero", obs);
      end
      tick(1'b1, 1'b0);
      tick(1'b1, 1'b1);
      for (int k = 1; k <= LOCK_CNT; k++) begin
         pulse_after(N);
         want_l = (k == LOCK_CNT);
         checks++;
         if (mon.locked !== want_l) begin
            errors++;
            $display("FAIL reacquire k=%0d got %b want %b", k, mon.locked, want_l);
         end
      end
   endtask

   task automatic test_disable();
      resetn = 1'b0;
      tick(1'b0, 1'b0);
      resetn = 1'b1;
      tick(1'b1, 1'b0);
      tick(1'b1, 1'b1);
      pulse_after(N);
      pulse_after(2);
      tick(1'b1, 1'b0);
      for (int i = 0; i < 10; i++) begin
         tick(1'b0, (i % N) == 1);
         checks++;
         if (obs !== {1'b0, 1'b0, 1'b0, W'(2)}) begin
            errors++;
            $display("FAIL disabled i=%0d got %b want %b", i, obs, {1'b0, 1'b0, 1'b0, W'(2)});
         end
      end
      tick(1'b1, 1'b1);
      tick(1'b1, 1'b0);
      tick(1'b1, 1'b1);
      checks++;
      if (obs !== {1'b0, 1'b0, 1'b0, W'(2)}) begin
         errors++;
         $display("FAIL reenable_seek got %b want %b", obs, {1'b0, 1'b0, 1'b0, W'(2)});
      end
      pulse_after(N);
      checks++;
      if (obs !== {1'b0, 1'b0, 1'b0, W'(N)}) begin
         errors++;
         $display("FAIL reenable_acq got %b want %b", obs, {1'b0, 1'b0, 1'b0, W'(N)});
      end
   endtask

`ifdef PULSE_MON_ERRCNT_EN
   task automatic test_err_count();
      resetn = 1'b0;
      tick(1'b0, 1'b0);
      resetn = 1'b1;
      tick(1'b1, 1'b0);
      tick(1'b1, 1'b1);
      repeat (3) pulse_after(1);
      repeat (2*N + 1) tick(1'b1, 1'b0);
      checks++;
      if (mon.err_count !== 8'd4) begin
         errors++;
         $display("FAIL err_count_4 got %0d want 4", mon.err_count);
      end
      repeat (5) tick(1'b0, 1'b0);
      checks++;
      if (mon.err_count !== 8'd4) begin
         errors++;
         $display("FAIL err_count_hold got %0d want 4", mon.err_count);
      end
      tick(1'b1, 1'b0);
      tick(1'b1, 1'b1);
      repeat (300) pulse_after(1);
      checks++;
      if (mon.err_count !== 8'd255) begin
         errors++;
         $display("FAIL err_count_sat got %0d want 255", mon.err_count);
      end
   endtask
`endif

   task automatic test_random();
      int  gap_left = 1;
      int  off_left = 0;
      bit  en;
      bit  p;
      resetn = 1'b0;
      tick(1'b0, 1'b0);
      resetn = 1'b1;
      for (int c = 0; c < 4000; c++) begin
         resetn = ($urandom_range(0, 799) != 0);
         if (off_left > 0) off_left--;
         else if ($urandom_range(0, 63) == 0) off_left = $urandom_range(1, 12);
         en = (off_left == 0);
         gap_left--;
         p = (gap_left == 0);
         if (p) gap_left = ($urandom_range(0, 3) != 0) ? N : $urandom_range(1, 2*N + 2);
         tick(en, p);
         checks++;
         if (obs !== model_vec()) begin
            errors++;
            $display("FAIL random c=%0d got %b want %b", c, obs, model_vec());
         end
`ifdef PULSE_MON_ERRCNT_EN
         checks++;
         if (mon.err_count !== 8'(m_errc)) begin
            errors++;
            $display("FAIL random_errc c=%0d got %0d want %0d", c, mon.err_count, m_errc);
         end
`endif
      end
      resetn = 1'b1;
   endtask

   initial begin
      mon.enable   = 1'b0;
      mon.pulse_in = 1'b0;
      test_reset();
      test_lock();
      test_bad_interval();
      test_timeout();
      test_reset_mid_lock();
      test_disable();
`ifdef PULSE_MON_ERRCNT_EN
      test_err_count();
`endif
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
